// File: rtl/piso_serial_tx.sv
// piso_serial_tx: valid/ready parallel-in, serial-out frame transmitter
// (start, LSB-first data, optional parity, stop; each bit held CLKS_PER_BIT clocks).
module piso_serial_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             tx,
   output logic             busy,
   output logic             done
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [IW-1:0]    r_idx, w_idx_nxt;
   logic [WIDTH-1:0] r_sh;
   logic             r_par;
   logic             w_last, w_accept, w_tx_nxt, w_done_nxt;

   assign w_last   = r_cnt == CW'(CLKS_PER_BIT - 1);
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_last ? '0 : r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            if (w_accept) w_state_nxt = S_START;
         end
         S_START:  if (w_last) w_state_nxt = S_DATA;
         S_DATA: if (w_last) begin
            if (r_idx == IW'(WIDTH - 1)) w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
            else w_idx_nxt = r_idx + 1'b1;
         end
         S_PARITY: if (w_last) w_state_nxt = S_STOP;
         S_STOP: if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // outputs are registered from the next-state view so they line up with the state
   assign w_tx_nxt = (w_state_nxt == S_START)  ? 1'b0 :
                     (w_state_nxt == S_DATA)   ? r_sh[w_idx_nxt] :
                     (w_state_nxt == S_PARITY) ? r_par : 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sh  <= '0;
         r_par <= 1'b0;
      end else if (w_accept) begin
         r_sh  <= in_data;
         r_par <= (^in_data) ^ PARITY_ODD;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx       <= 1'b1;
         busy     <= 1'b0;
         in_ready <= 1'b1;
         done     <= 1'b0;
      end else begin
         tx       <= w_tx_nxt;
         busy     <= w_state_nxt != S_IDLE;
         in_ready <= w_state_nxt == S_IDLE;
         done     <= w_done_nxt;
      end
   end
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: directed bench with a bit-level scoreboard for three transmitter
// variants (no parity, even parity, odd parity), all at WIDTH=8, CLKS_PER_BIT=4.
module tb_piso_serial_tx;
   localparam int W   = 8;
   localparam int CPB = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] in_data = '0;
   logic [2:0]   valid_v = '0;
   logic [2:0]   ready_v, tx_v, busy_v, done_v;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   piso_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_np (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_v[0]), .in_ready(ready_v[0]),
      .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   piso_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_ev (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_v[1]), .in_ready(ready_v[1]),
      .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   piso_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_od (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_v[2]), .in_ready(ready_v[2]),
      .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // expected line level for each bit of the frame, start bit first
   task automatic push_frame(input logic [W-1:0] w, input bit pen, input bit podd);
      exp_q.push_back(1'b0);
      for (int i = 0; i < W; i++) exp_q.push_back(w[i]);
      if (pen) exp_q.push_back((^w) ^ podd);
      exp_q.push_back(1'b1);
   endtask

   // called at a negedge; returns at the negedge in the first START cycle
   task automatic drive(input int k, input logic [W-1:0] w, input bit pen, input bit podd);
      int t = 0;
      in_data    = w;
      valid_v[k] = 1'b1;
      while (!ready_v[k] && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("accept_ready", {31'd0, ready_v[k]}, 32'd1);
      push_frame(w, pen, podd);
      @(negedge clk);
   endtask

   // checks nbits bits then the done cycle; pulse_at injects a one-cycle in_valid mid-frame
   task automatic check_frame(input int k, input int nbits, input int pulse_at);
      int c = 0;
      bit b;
      for (int i = 0; i < nbits; i++) begin
         b = exp_q.pop_front();
         for (int j = 0; j < CPB; j++) begin
            chk("tx_bit",    {31'd0, tx_v[k]},    {31'd0, b});
            chk("busy_high", {31'd0, busy_v[k]},  32'd1);
            chk("ready_low", {31'd0, ready_v[k]}, 32'd0);
            chk("done_low",  {31'd0, done_v[k]},  32'd0);
            if (c == pulse_at) begin
               valid_v[k] = 1'b1;
               in_data    = ~in_data;
            end else if (c == pulse_at + 1) valid_v[k] = 1'b0;
            c++;
            @(negedge clk);
         end
      end
      chk("done_pulse", {31'd0, done_v[k]},  32'd1);
      chk("done_tx",    {31'd0, tx_v[k]},    32'd1);
      chk("done_busy",  {31'd0, busy_v[k]},  32'd0);
      chk("done_ready", {31'd0, ready_v[k]}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_tx",    {31'd0, tx_v[k]},    32'd1);
         chk("rst_ready", {31'd0, ready_v[k]}, 32'd1);
         chk("rst_busy",  {31'd0, busy_v[k]},  32'd0);
         chk("rst_done",  {31'd0, done_v[k]},  32'd0);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_tx",    {31'd0, tx_v[0]},    32'd1);
      chk("idle_ready", {31'd0, ready_v[0]}, 32'd1);
      chk("idle_busy",  {31'd0, busy_v[0]},  32'd0);

      drive(0, 8'hA5, 1'b0, 1'b0);
      valid_v[0] = 1'b0;
      check_frame(0, 10, 1000);
      @(negedge clk);
      chk("a5_done_once", {31'd0, done_v[0]}, 32'd0);

      // back-to-back with in_valid held and in_data changed during the first frame
      drive(0, 8'h3C, 1'b0, 1'b0);
      in_data = 8'hFF;
      push_frame(8'hFF, 1'b0, 1'b0);
      check_frame(0, 10, 1000);
      @(negedge clk);
      valid_v[0] = 1'b0;
      chk("b2b_done_once", {31'd0, done_v[0]}, 32'd0);
      check_frame(0, 10, 1000);
      @(negedge clk);

      drive(0, 8'h5A, 1'b0, 1'b0);
      valid_v[0] = 1'b0;
      check_frame(0, 10, 13);
      repeat (2) @(negedge clk);
      chk("no_extra_busy",  {31'd0, busy_v[0]},  32'd0);
      chk("no_extra_ready", {31'd0, ready_v[0]}, 32'd1);

      drive(1, 8'h07, 1'b1, 1'b0);
      valid_v[1] = 1'b0;
      check_frame(1, 11, 1000);
      @(negedge clk);
      drive(2, 8'h07, 1'b1, 1'b1);
      valid_v[2] = 1'b0;
      check_frame(2, 11, 1000);
      @(negedge clk);

      // reset during DATA bit 3 of 0x96 (that bit is 0 on the line)
      drive(0, 8'h96, 1'b0, 1'b0);
      valid_v[0] = 1'b0;
      repeat (17) @(negedge clk);
      chk("pre_rst_tx", {31'd0, tx_v[0]}, 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("async_tx",    {31'd0, tx_v[0]},    32'd1);
      chk("async_busy",  {31'd0, busy_v[0]},  32'd0);
      chk("async_ready", {31'd0, ready_v[0]}, 32'd1);
      chk("async_done",  {31'd0, done_v[0]},  32'd0);
      exp_q.delete();
      @(negedge clk);
      repeat (2) begin
         chk("rst_no_done", {31'd0, done_v[0]}, 32'd0);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      drive(0, 8'h69, 1'b0, 1'b0);
      valid_v[0] = 1'b0;
      check_frame(0, 10, 1000);
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
